// File: rtl/msx_cart_pkg.sv
// Shared definitions for the MSX cartridge CPLD.
// Holds the mapper mode encodings and the per-mode bank reset values.
// No ports; imported by the mapper and by later cartridge blocks.
package msx_cart_pkg;

    localparam logic [2:0] MODE_OFF        = 3'd0;
    localparam logic [2:0] MODE_ASCII8     = 3'd1;
    localparam logic [2:0] MODE_ASCII16    = 3'd2;
    localparam logic [2:0] MODE_KONAMI     = 3'd3;
    localparam logic [2:0] MODE_KONAMI_SCC = 3'd4;

    // Encodings 5..7 are not mappers; fold them to OFF so MODE only ever
    // reports a mode the address path actually implements.
    function automatic logic [2:0] mode_normalize(input logic [2:0] m);
        return (m > MODE_KONAMI_SCC) ? MODE_OFF : m;
    endfunction

    // Bank value a mapper comes up with when selected.
    function automatic logic [1:0] bank_reset_val(input logic [2:0] m, input logic [1:0] idx);
        case (m)
            MODE_ASCII16:                 return {1'b0, idx[0]};
            MODE_KONAMI, MODE_KONAMI_SCC: return idx;
            default:                      return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/msx_bank_mapper_if.sv
// MSX slot bus as seen by the bank mapper, plus the mapped SRAM side.
// Ports (signals):
//   MSX_A, MSX_Din, MSX_nWR, MSX_nRD, MSX_nSLTSL : slot bus, driven by master
//   SRAM_Addr, ROM_SEL, SCC_SEL                 : mapper results, driven by slave
interface msx_bank_mapper_if #(
    parameter int SRAM_AW = 19
);
    logic [15:0]        MSX_A;
    logic [7:0]         MSX_Din;
    logic               MSX_nWR;
    logic               MSX_nRD;
    logic               MSX_nSLTSL;
    logic [SRAM_AW-1:0] SRAM_Addr;
    logic               ROM_SEL;
    logic               SCC_SEL;

    modport master (
        output MSX_A, MSX_Din, MSX_nWR, MSX_nRD, MSX_nSLTSL,
        input  SRAM_Addr, ROM_SEL, SCC_SEL
    );

    modport slave (
        input  MSX_A, MSX_Din, MSX_nWR, MSX_nRD, MSX_nSLTSL,
        output SRAM_Addr, ROM_SEL, SCC_SEL
    );
endinterface

// File: rtl/msx_wr_edge.sv
// Registered rising-edge strobe on an active-high level: stb is high for
// the single cycle in which lvl is high but was low at the previous edge.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   lvl      : level to watch (e.g. a decoded active-low write strobe)
//   stb      : one-cycle strobe, combinational from lvl
module msx_wr_edge (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic stb
);
    logic lvl_q;

    // Clearing lvl_q on reset lets a level still held across reset
    // produce one fresh strobe once reset releases.
    always_ff @(posedge clk) begin
        if (rst) lvl_q <= 1'b0;
        else     lvl_q <= lvl;
    end

    assign stb = lvl & ~lvl_q;
endmodule

// File: rtl/msx_bank_mapper.sv
// MegaROM bank mapper between the MSX slot bus and external SRAM.
// Supports OFF (linear), ASCII8, ASCII16, Konami and Konami-SCC mappers.
// Ports:
//   MSX_CLK, MSX_RESET : bus clock, synchronous active-high reset
//   bus                : slot bus in, SRAM_Addr / ROM_SEL / SCC_SEL out
//   CFG_WE/MODE/MASK   : one-cycle config load from the SPI decoder
//   MODE               : currently registered mode
module msx_bank_mapper
    import msx_cart_pkg::*;
#(
    parameter  int SRAM_AW = 19,
    localparam int BW      = SRAM_AW - 13
) (
    input  logic             MSX_CLK,
    input  logic             MSX_RESET,
    msx_bank_mapper_if.slave bus,
    input  logic             CFG_WE,
    input  logic [2:0]       CFG_MODE,
    input  logic [BW-1:0]    CFG_MASK,
    output logic [2:0]       MODE
);
    logic [2:0]    mode_r;
    logic [BW-1:0] mask_r;
    logic [BW-1:0] bank [4];

    logic          wr_now;
    logic          wr_stb;
    logic [3:0]    bank_we;
    logic [BW-1:0] bank_wd [4];
    logic [BW-1:0] d;
    logic [4:0]    win2k;
    logic [2:0]    win8k;
    logic [2:0]    page3;
    logic [1:0]    page;
    logic          in_rom;
    logic [7:0]    b2_ext;
    logic          unused_bits;

    assign wr_now = ~bus.MSX_nWR & ~bus.MSX_nSLTSL;

    msx_wr_edge u_wr_edge (
        .clk (MSX_CLK),
        .rst (MSX_RESET),
        .lvl (wr_now),
        .stb (wr_stb)
    );

    assign win2k = bus.MSX_A[15:11];
    assign win8k = bus.MSX_A[15:13];
    assign d     = bus.MSX_Din[BW-1:0];

    // Write decode: which banks a write at the current address would load.
    always_comb begin
        bank_we = '0;
        for (int i = 0; i < 4; i++) bank_wd[i] = d;
        case (mode_r)
            MODE_ASCII8: begin
                case (win2k)
                    5'h0C:   bank_we[0] = 1'b1;
                    5'h0D:   bank_we[1] = 1'b1;
                    5'h0E:   bank_we[2] = 1'b1;
                    5'h0F:   bank_we[3] = 1'b1;
                    default: ;
                endcase
            end
            MODE_ASCII16: begin
                // One 16 KB bank maps to an even/odd pair of 8 KB pages.
                bank_wd[0] = {d[BW-2:0], 1'b0};
                bank_wd[1] = {d[BW-2:0], 1'b1};
                bank_wd[2] = {d[BW-2:0], 1'b0};
                bank_wd[3] = {d[BW-2:0], 1'b1};
                if (win2k == 5'h0C)      bank_we = 4'b0011;
                else if (win2k == 5'h0E) bank_we = 4'b1100;
            end
            MODE_KONAMI: begin
                case (win8k)
                    3'd3:    bank_we[1] = 1'b1;
                    3'd4:    bank_we[2] = 1'b1;
                    3'd5:    bank_we[3] = 1'b1;
                    default: ;
                endcase
            end
            MODE_KONAMI_SCC: begin
                case (win2k)
                    5'h0A:   bank_we[0] = 1'b1;
                    5'h0E:   bank_we[1] = 1'b1;
                    5'h12:   bank_we[2] = 1'b1;
                    5'h16:   bank_we[3] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Config load takes priority over a coincident bus write.
    always_ff @(posedge MSX_CLK) begin
        if (MSX_RESET) begin
            mode_r <= MODE_OFF;
            mask_r <= '1;
            for (int i = 0; i < 4; i++) bank[i] <= '0;
        end else if (CFG_WE) begin
            mode_r <= mode_normalize(CFG_MODE);
            mask_r <= CFG_MASK;
            for (int i = 0; i < 4; i++)
                bank[i] <= BW'(bank_reset_val(mode_normalize(CFG_MODE), 2'(i)));
        end else if (wr_stb) begin
            for (int i = 0; i < 4; i++)
                if (bank_we[i]) bank[i] <= bank_wd[i];
        end
    end

    assign in_rom = (bus.MSX_A[15:14] == 2'b01) || (bus.MSX_A[15:14] == 2'b10);
    assign page3  = win8k - 3'd2;
    assign page   = page3[1:0];

    assign bus.SRAM_Addr = (mode_r != MODE_OFF && in_rom)
                         ? {bank[page] & mask_r, bus.MSX_A[12:0]}
                         : SRAM_AW'(bus.MSX_A[13:0]);

    assign bus.ROM_SEL = ~bus.MSX_nSLTSL & ~bus.MSX_nRD & in_rom;

    // The SCC register window opens only while bank 2 holds 0x3F,
    // unmasked, whatever the ROM size.
    assign b2_ext      = 8'(bank[2]);
    assign bus.SCC_SEL = (mode_r == MODE_KONAMI_SCC) & ~bus.MSX_nSLTSL
                       & (win2k == 5'h13) & (b2_ext[5:0] == 6'h3F);

    assign MODE = mode_r;

    assign unused_bits = ^{bus.MSX_Din, page3[2], b2_ext[7:6]};
endmodule

// File: tb/tb_msx_bank_mapper.sv
// Self-checking bench for msx_bank_mapper: directed steps followed by a
// randomized run, all compared against a behavioural model of the mapper.
module tb_msx_bank_mapper;
    localparam int          SRAM_AW = 19;
    localparam int          BW      = SRAM_AW - 13;
    localparam int unsigned BMASK   = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_mode = 3'd0;
    logic [BW-1:0] cfg_mask = '0;
    logic [2:0]    mode;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned bank_m [4];
    int unsigned mode_m;
    int unsigned mask_m;

    msx_bank_mapper_if #(.SRAM_AW(SRAM_AW)) bus ();

    msx_bank_mapper #(.SRAM_AW(SRAM_AW)) dut (
        .MSX_CLK   (clk),
        .MSX_RESET (rst),
        .bus       (bus),
        .CFG_WE    (cfg_we),
        .CFG_MODE  (cfg_mode),
        .CFG_MASK  (cfg_mask),
        .MODE      (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(int unsigned a, int unsigned lo, int unsigned hi);
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic void model_reset();
        mode_m = 0;
        mask_m = BMASK;
        for (int i = 0; i < 4; i++) bank_m[i] = 0;
    endfunction

    function automatic void model_cfg(int unsigned m, int unsigned k);
        mode_m = (m > 4) ? 0 : m;
        mask_m = k & BMASK;
        for (int i = 0; i < 4; i++) begin
            if (mode_m == 2)                     bank_m[i] = i % 2;
            else if (mode_m == 3 || mode_m == 4) bank_m[i] = i;
            else                                 bank_m[i] = 0;
        end
    endfunction

    function automatic void model_write(int unsigned a, int unsigned data);
        int unsigned dd;
        dd = data & BMASK;
        case (mode_m)
            1: begin
                if (in_rng(a, 'h6000, 'h67FF)) bank_m[0] = dd;
                if (in_rng(a, 'h6800, 'h6FFF)) bank_m[1] = dd;
                if (in_rng(a, 'h7000, 'h77FF)) bank_m[2] = dd;
                if (in_rng(a, 'h7800, 'h7FFF)) bank_m[3] = dd;
            end
            2: begin
                if (in_rng(a, 'h6000, 'h67FF)) begin
                    bank_m[0] = (dd * 2) & BMASK;
                    bank_m[1] = (dd * 2 + 1) & BMASK;
                end
                if (in_rng(a, 'h7000, 'h77FF)) begin
                    bank_m[2] = (dd * 2) & BMASK;
                    bank_m[3] = (dd * 2 + 1) & BMASK;
                end
            end
            3: begin
                if (in_rng(a, 'h6000, 'h7FFF)) bank_m[1] = dd;
                if (in_rng(a, 'h8000, 'h9FFF)) bank_m[2] = dd;
                if (in_rng(a, 'hA000, 'hBFFF)) bank_m[3] = dd;
            end
            4: begin
                if (in_rng(a, 'h5000, 'h57FF)) bank_m[0] = dd;
                if (in_rng(a, 'h7000, 'h77FF)) bank_m[1] = dd;
                if (in_rng(a, 'h9000, 'h97FF)) bank_m[2] = dd;
                if (in_rng(a, 'hB000, 'hB7FF)) bank_m[3] = dd;
            end
            default: ;
        endcase
    endfunction

    function automatic int unsigned exp_addr(int unsigned a);
        if (mode_m != 0 && in_rng(a, 'h4000, 'hBFFF))
            return ((bank_m[(a >> 13) - 2] & mask_m) << 13) | (a & 'h1FFF);
        return a & 'h3FFF;
    endfunction

    task automatic do_cfg(input int unsigned m, input int unsigned k);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_mode = 3'(m);
        cfg_mask = BW'(k);
        @(negedge clk);
        cfg_we = 1'b0;
        model_cfg(m, k);
        if (m <= 4) chk("cfg_mode", 32'(mode), m);
    endtask

    // Holds the write for 'hold' cycles; data is scrambled after the first
    // sampled edge so a level-triggered mapper would load the wrong value.
    task automatic do_write(input int unsigned a, input int unsigned data, input int hold);
        @(negedge clk);
        bus.MSX_A      = 16'(a);
        bus.MSX_Din    = 8'(data);
        bus.MSX_nSLTSL = 1'b0;
        bus.MSX_nWR    = 1'b0;
        @(negedge clk);
        model_write(a, data);
        for (int i = 1; i < hold; i++) begin
            bus.MSX_Din = 8'($urandom);
            @(negedge clk);
        end
        bus.MSX_nWR    = 1'b1;
        bus.MSX_nSLTSL = 1'b1;
    endtask

    task automatic do_read(input int unsigned a, input logic nsl, input string tag);
        @(negedge clk);
        bus.MSX_A      = 16'(a);
        bus.MSX_nRD    = 1'b0;
        bus.MSX_nSLTSL = nsl;
        #1;
        chk({tag, ".addr"}, 32'(bus.SRAM_Addr), exp_addr(a));
        chk({tag, ".rom_sel"}, 32'(bus.ROM_SEL),
            32'(!nsl && in_rng(a, 'h4000, 'hBFFF)));
        chk({tag, ".scc_sel"}, 32'(bus.SCC_SEL),
            32'(mode_m == 4 && !nsl && in_rng(a, 'h9800, 'h9FFF) && (bank_m[2] & 'h3F) == 'h3F));
        bus.MSX_nRD    = 1'b1;
        bus.MSX_nSLTSL = 1'b1;
    endtask

    initial begin
        int unsigned bases [10];
        int unsigned a, r;

        bases = '{'h5000, 'h6000, 'h6800, 'h7000, 'h7800,
                  'h8000, 'h9000, 'h9800, 'hA000, 'hB000};

        bus.MSX_A      = 16'h0000;
        bus.MSX_Din    = 8'h00;
        bus.MSX_nWR    = 1'b1;
        bus.MSX_nRD    = 1'b1;
        bus.MSX_nSLTSL = 1'b1;
        model_reset();

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("reset_mode", 32'(mode), 0);
        do_read('h4123, 1'b0, "rst_rd4123");
        chk("rst_addr_const", 32'(bus.SRAM_Addr), 32'h00123);
        do_read('hC123, 1'b0, "rst_rdC123");
        do_read('h8123, 1'b1, "rst_noslot");

        // ASCII8
        do_cfg(1, 'h3F);
        do_write('h7000, 'h05, 1);
        do_read('h8001, 1'b0, "a8_rd8001");
        chk("a8_addr_const", 32'(bus.SRAM_Addr), 32'h0A001);
        do_write('h7800, 'h11, 4);
        do_read('hA000, 1'b0, "a8_held");
        chk("a8_held_const", 32'(bus.SRAM_Addr), 32'h22000);

        // ASCII16
        do_cfg(2, 'h3F);
        do_write('h6000, 'h03, 2);
        do_read('h6010, 1'b0, "a16_rd6010");
        chk("a16_addr_const", 32'(bus.SRAM_Addr), 32'h0E010);
        do_read('h4010, 1'b0, "a16_rd4010");
        do_write('h7000, 'h3F, 1);
        do_read('hA123, 1'b0, "a16_topbit");

        // Konami
        do_cfg(3, 'h3F);
        do_write('h4000, 'h09, 1);
        do_write('hA000, 'h09, 1);
        do_read('hA000, 1'b0, "kon_rdA000");
        chk("kon_addr_const", 32'(bus.SRAM_Addr), 32'h12000);
        do_read('h4000, 1'b0, "kon_rd4000");
        chk("kon_b0_const", 32'(bus.SRAM_Addr), 32'h00000);

        // Konami-SCC
        do_cfg(4, 'h1F);
        do_write('h9000, 'h3F, 1);
        do_read('h9800, 1'b0, "scc_rd9800");
        chk("scc_sel_const", 32'(bus.SCC_SEL), 32'h1);
        do_read('h8000, 1'b0, "scc_rd8000");
        chk("scc_addr_const", 32'(bus.SRAM_Addr), 32'h3E000);

        // Config strobe coincident with a bus write: the write is lost
        do_cfg(1, 'h3F);
        do_write('h6000, 'h15, 1);
        @(negedge clk);
        cfg_we         = 1'b1;
        cfg_mode       = 3'd3;
        cfg_mask       = BW'('h3F);
        bus.MSX_A      = 16'h6000;
        bus.MSX_Din    = 8'h2A;
        bus.MSX_nSLTSL = 1'b0;
        bus.MSX_nWR    = 1'b0;
        @(negedge clk);
        cfg_we         = 1'b0;
        bus.MSX_nWR    = 1'b1;
        bus.MSX_nSLTSL = 1'b1;
        model_cfg(3, 'h3F);
        do_read('h6000, 1'b0, "coinc_rd6000");
        chk("coinc_const", 32'(bus.SRAM_Addr), 32'h02000);
        do_read('h4000, 1'b0, "coinc_rd4000");

        // Out-of-range mode behaves as linear
        do_cfg(6, 'h3F);
        do_write('h7000, 'h07, 1);
        do_read('h8123, 1'b0, "bad_mode");

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 'hFFFF);
            else                           a = bases[$urandom_range(0, 9)] + $urandom_range(0, 'h7FF);
            if (r == 0)
                do_cfg($urandom_range(0, 7), (1 << $urandom_range(1, BW)) - 1);
            else if (r <= 4)
                do_write(a, $urandom_range(0, 255), int'($urandom_range(1, 3)));
            else
                do_read(a, 1'($urandom_range(0, 4) == 0), "rand");
        end

        // Reset asserted during a held write
        do_cfg(1, 'h3F);
        @(negedge clk);
        bus.MSX_A      = 16'h7000;
        bus.MSX_Din    = 8'h07;
        bus.MSX_nSLTSL = 1'b0;
        bus.MSX_nWR    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        bus.MSX_nWR    = 1'b1;
        bus.MSX_nSLTSL = 1'b1;
        chk("midwr_reset_mode", 32'(mode), 0);
        do_read('h9ABC, 1'b0, "midwr_reset_rd");
        do_cfg(2, 'h3F);
        do_read('h6000, 1'b0, "post_reset_a16");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
